// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue, non-pipelined controller between instruction
// fetch and the master ALU. It owns the 16x32 register file and the {N,Z,C,V}
// flag register. It resolves the condition code locally, feeds operands to the
// ALU, and writes back the ALU result.
//
// Handshake: an instruction word transfers on a rising clk edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE. A word offered
// while the controller is busy is neither latched nor acknowledged. The
// producer must hold instr stable while instr_valid is high and ready is low.
module alu_issue_ctrl #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_reg1,
    output logic [DW-1:0] alu_reg2,
    output logic [4:0]    alu_iv_shft,
    output logic [15:0]   alu_iv_mov,
    output logic [3:0]    alu_opcode,
    output logic [3:0]    alu_cond,
    output logic          alu_s,
    output logic [3:0]    alu_flag,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_new_flag,
    output logic          done,
    output logic          executed,
    output logic          illegal,
    output logic [3:0]    flags,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EX   = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_MOVN = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1011;

    state_t        state, state_nx;
    logic [31:0]   instr_q;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] op_a, op_b, res_q;
    logic [3:0]    flag_q, nflag_q;
    logic          pass_q, illegal_q;

    // Fields of the latched instruction word
    logic [3:0] cond_f, op_f, rd_f, rn_f, rm_f;
    logic       s_f, legal, cond_ok, wr_rf, wr_flag;
    logic       fn, fz, fc, fv;

    assign cond_f = instr_q[31:28];
    assign op_f   = instr_q[27:24];
    assign rd_f   = instr_q[23:20];
    assign rn_f   = instr_q[19:16];
    assign rm_f   = instr_q[15:12];
    assign s_f    = instr_q[11];
    assign legal  = ~(op_f[3] & op_f[2]);
    assign {fn, fz, fc, fv} = flag_q;

    // CMP always updates flags. The two move ops never do. Everything else follows S.
    assign wr_rf   = pass_q && (op_f != OP_CMP);
    assign wr_flag = pass_q && ((op_f == OP_CMP) ||
                                (s_f && (op_f != OP_MOVN) && (op_f != OP_MOV)));

    // ALU-facing outputs come straight from the latched word and operand registers
    assign alu_reg1    = op_a;
    assign alu_reg2    = op_b;
    assign alu_iv_shft = instr_q[4:0];
    assign alu_iv_mov  = instr_q[15:0];
    assign alu_opcode  = op_f;
    assign alu_cond    = 4'b0000;
    assign alu_s       = s_f | (op_f == OP_CMP);
    assign alu_flag    = flag_q;
    assign flags       = flag_q;
    assign instr_ready = (state == IDLE);
    assign dbg_data    = rf[dbg_addr];
    assign dbg_state   = state;

    // Condition code evaluation against the architectural flags
    always_comb begin
        cond_ok = 1'b0;
        case (cond_f)
            4'b0000: cond_ok = 1'b1;
            4'b0001: cond_ok = fz;
            4'b0010: cond_ok = ~fz & (fn == fv);
            4'b0011: cond_ok = (fn != fv);
            4'b0100: cond_ok = (fn == fv);
            4'b0101: cond_ok = fz | (fn != fv);
            4'b0110: cond_ok = fc & ~fz;
            4'b0111: cond_ok = ~fc;
            4'b1000: cond_ok = fc;
            default: cond_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and retire outputs; a failed condition or illegal op skips EX
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        executed = 1'b0;
        illegal  = 1'b0;
        case (state)
            IDLE: if (instr_valid) state_nx = RD;
            RD:   state_nx = (legal && cond_ok) ? EX : WB;
            EX:   state_nx = WB;
            WB: begin
                done     = 1'b1;
                executed = pass_q;
                illegal  = illegal_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the instruction word only on an accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            instr_q <= '0;
        else if (state == IDLE && instr_valid) instr_q <= instr;
    end

    // Operand fetch and condition resolution in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            pass_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state == RD) begin
            op_a      <= rf[rn_f];
            op_b      <= rf[rm_f];
            pass_q    <= legal && cond_ok;
            illegal_q <= ~legal;
        end
    end

    // Capture the ALU result at the end of EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            nflag_q <= '0;
        end else if (state == EX) begin
            res_q   <= alu_result;
            nflag_q <= alu_new_flag;
        end
    end

    // Register file and flag writeback, only in WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            flag_q <= '0;
        end else if (state == WB) begin
            if (wr_rf)   rf[rd_f] <= res_q;
            if (wr_flag) flag_q   <= nflag_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random instructions are checked against
// an instruction-level model of the register file and flags. A behavioural ALU
// stub answers the controller.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] alu_reg1, alu_reg2, alu_result, dbg_data;
    logic [4:0]  alu_iv_shft;
    logic [15:0] alu_iv_mov;
    logic [3:0]  alu_opcode, alu_cond, alu_flag, alu_new_flag, flags;
    logic [3:0]  dbg_addr = '0;
    logic [1:0]  dbg_state;
    logic        alu_s, done, executed, illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [16];
    logic [3:0]  m_flags;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_iv_shft(alu_iv_shft),
        .alu_iv_mov(alu_iv_mov), .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s),
        .alu_flag(alu_flag), .alu_result(alu_result), .alu_new_flag(alu_new_flag),
        .done(done), .executed(executed), .illegal(illegal), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {N,Z,C,V, result}
    function automatic logic [35:0] alu_eval(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh,
                                             input logic [15:0] imm);
        logic [31:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1, 4'd11: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2:  r = a * b;
            4'd3:  r = a | b;
            4'd4:  r = a & b;
            4'd5:  r = a ^ b;
            4'd6:  r = {16'h0, imm};
            4'd7:  r = b;
            4'd8:  r = a >> sh;
            4'd9:  r = a << sh;
            4'd10: r = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            default: r = '0;
        endcase
        return {r[31], (r == 0), c, v, r};
    endfunction

    always_comb {alu_new_flag, alu_result} = alu_eval(alu_opcode, alu_reg1, alu_reg2, alu_iv_shft, alu_iv_mov);

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0: return 1'b1;
            4'd1: return z;
            4'd2: return !z && (n == v);
            4'd3: return n != v;
            4'd4: return n == v;
            4'd5: return z || (n != v);
            4'd6: return cy && !z;
            4'd7: return !cy;
            4'd8: return cy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mk_r(input logic [3:0] c, input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rn, input logic [3:0] rm, input logic s,
                                         input logic [4:0] sh);
        return {c, op, rd, rn, rm, s, 6'b0, sh};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] c, input logic [3:0] op, input logic [3:0] rd,
                                         input logic [15:0] imm);
        return {c, op, rd, 4'h0, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_flags = '0;
    endtask

    // Issue one word, follow it to retirement and compare against the model
    task automatic issue(input logic [31:0] w);
        logic [3:0] c, op, rd, rn, rm;
        logic s, pass, legal;
        logic [35:0] fr;
        logic [31:0] old_a;
        int exp_lat, lat;
        logic [3:0] rr;
        c = w[31:28]; op = w[27:24]; rd = w[23:20]; rn = w[19:16]; rm = w[15:12]; s = w[11];
        legal = (op < 4'd12);
        pass = legal && cond_pass(c, m_flags);
        old_a = m_rf[rn];
        exp_lat = pass ? 3 : 2;
        if (pass) begin
            fr = alu_eval(op, m_rf[rn], m_rf[rm], w[4:0], w[15:0]);
            if (op != 4'd11) m_rf[rd] = fr[31:0];
            if (op == 4'd11 || (s && op != 4'd6 && op != 4'd7)) m_flags = fr[35:32];
        end
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr = w; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        check("ready_busy", instr_ready, 0);
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            if (lat == 2 && pass) begin
                check("alu_reg1", alu_reg1, old_a);
                check("alu_s", alu_s, s | (op == 4'd11));
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("executed", executed, pass);
        check("illegal", illegal, !legal);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("flags", flags, m_flags);
        check_reg("rf_rd", rd, m_rf[rd]);
        rr = 4'($urandom_range(0, 15));
        check_reg("rf_any", rr, m_rf[rr]);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0] c;
        model_reset();
        // Reset state
        #12;
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_flags", flags, 0);
        check("rst_reg1", alu_reg1, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_state", dbg_state, 0);
        check_reg("rst_rf", 4'd9, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence
        issue(mk_i(4'd0, 4'd6, 4'd1, 16'h0005));
        issue(mk_i(4'd0, 4'd6, 4'd2, 16'h0003));
        check_reg("movn_r1", 4'd1, 32'd5);
        check_reg("movn_r2", 4'd2, 32'd3);
        issue(mk_r(4'd0, 4'd0, 4'd3, 4'd1, 4'd2, 1'b1, 5'd0));
        check_reg("add_r3", 4'd3, 32'd8);
        check("add_flags", flags, 4'b0000);
        issue(mk_r(4'd0, 4'd1, 4'd4, 4'd2, 4'd2, 1'b1, 5'd0));
        check_reg("sub_r4", 4'd4, 32'd0);
        check("sub_flags", flags, 4'b0100);
        issue(mk_r(4'd1, 4'd7, 4'd5, 4'd0, 4'd1, 1'b0, 5'd0));
        check_reg("mov_eq_r5", 4'd5, 32'd5);
        issue(mk_r(4'd7, 4'd7, 4'd8, 4'd0, 4'd2, 1'b0, 5'd0));
        check_reg("mov_cc_r8", 4'd8, 32'd3);
        issue(mk_r(4'd8, 4'd7, 4'd9, 4'd0, 4'd1, 1'b0, 5'd0));
        check_reg("mov_cs_r9", 4'd9, 32'd0);
        issue(mk_r(4'd0, 4'd11, 4'd10, 4'd1, 4'd2, 1'b0, 5'd0));
        check("cmp_flags", flags, 4'b0000);
        check_reg("cmp_r10", 4'd10, 32'd0);
        issue(mk_r(4'd0, 4'd13, 4'd11, 4'd1, 4'd2, 1'b1, 5'd0));
        check_reg("illegal_r11", 4'd11, 32'd0);
        issue(mk_r(4'd0, 4'd10, 4'd12, 4'd3, 4'd0, 1'b0, 5'd1));
        check_reg("ror_r12", 4'd12, 32'd4);

        // Back-to-back: valid held high, a new word every cycle
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            w = mk_i(4'd0, 4'd6, 4'($urandom_range(0, 15)), 16'($urandom));
            instr = w; instr_valid = 1'b1;
            check("b2b_ready", instr_ready, (k % 4) == 0);
            check("b2b_done", done, (k % 4) == 3);
            if ((k % 4) == 0) m_rf[w[23:20]] = {16'h0, w[15:0]};
        end
        @(negedge clk);
        instr_valid = 1'b0;
        for (int r = 0; r < 16; r++) check_reg("b2b_rf", 4'(r), m_rf[r]);

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            issue({c, 4'($urandom_range(0, 15)), 24'($urandom)});
        end

        // Reset during EX of ADD R6
        issue(mk_i(4'd0, 4'd6, 4'd6, 16'h0007));
        @(negedge clk);
        instr = mk_r(4'd0, 4'd0, 4'd6, 4'd1, 4'd2, 1'b1, 5'd0); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_ready", instr_ready, 1);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_ready", instr_ready, 1);
        check("postrst_flags", flags, 0);
        check_reg("postrst_r6", 4'd6, 0);
        check_reg("postrst_r1", 4'd1, 0);
        @(negedge clk);
        check("postrst_no_done", done, 0);
        issue(mk_i(4'd0, 4'd6, 4'd6, 16'h1234));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
